// File: rtl/mc_alu.sv
// mc_alu: multi-cycle EX-stage ALU (and/or/add/sub in one cycle, shift-add multiply when MC_ALU_MUL_EN is defined)
module mc_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);
  logic [WIDTH-1:0] r_result, w_res;
  logic r_valid, r_zero, r_illegal, w_illegal;
  // single-cycle datapath; unsupported codes yield 0 and flag illegal
  always_comb begin
    w_res = ALUCtrl_i == 4'b0000 ? data1_i & data2_i :
            ALUCtrl_i == 4'b0001 ? data1_i | data2_i :
            ALUCtrl_i == 4'b0010 ? data1_i + data2_i :
            ALUCtrl_i == 4'b0110 ? data1_i - data2_i : '0;
    w_illegal = !(ALUCtrl_i == 4'b0000 || ALUCtrl_i == 4'b0001 ||
                  ALUCtrl_i == 4'b0010 || ALUCtrl_i == 4'b0110);
  end
  assign valid_o   = r_valid;
  assign result_o  = r_result;
  assign zero_o    = r_zero;
  assign illegal_o = r_illegal;
`ifdef MC_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_next;
  assign ready_o    = (r_state == IDLE);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  // FSM: single-cycle ops complete from IDLE; multiply iterates WIDTH edges in MUL with a fixed latency
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
    end else begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      if (flush_i) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state == IDLE) begin
        if (valid_i && ALUCtrl_i == 4'b0111) begin
          r_mcand  <= data1_i;
          r_mplier <= data2_i;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_state  <= MUL;
        end else if (valid_i) begin
          r_valid   <= 1'b1;
          r_illegal <= w_illegal;
          r_result  <= w_res;
          r_zero    <= (w_res == '0);
        end
      end else begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_valid  <= 1'b1;
          r_result <= w_acc_next;
          r_zero   <= (w_acc_next == '0);
          r_state  <= IDLE;
        end
      end
    end
  end
`else
  logic w_accept;
  assign ready_o  = 1'b1;
  assign w_accept = valid_i && !flush_i;
  // every accepted code completes in one cycle; 0111 decodes as illegal here
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
    end else begin
      r_valid   <= w_accept;
      r_illegal <= w_accept && w_illegal;
      if (w_accept) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
      end
    end
  end
`endif
endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: scoreboard bench for mc_alu; multiply tests follow MC_ALU_MUL_EN
module tb_mc_alu;
  localparam int W = 32;
  logic clk_i = 1'b0, rst_i = 1'b0, valid_i = 1'b0, flush_i = 1'b0;
  logic [3:0] ALUCtrl_i = '0;
  logic [W-1:0] data1_i = '0, data2_i = '0;
  logic ready_o, valid_o, zero_o, illegal_o;
  logic [W-1:0] result_o;
  typedef struct packed {logic [W-1:0] r; logic z; logic il;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  mc_alu #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUCtrl_i(ALUCtrl_i),
    .data1_i(data1_i), .data2_i(data2_i), .flush_i(flush_i), .ready_o(ready_o),
    .valid_o(valid_o), .result_o(result_o), .zero_o(zero_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.il = 1'b0;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: e.r = a + b;
      4'b0110: e.r = a - b;
`ifdef MC_ALU_MUL_EN
      4'b0111: e.r = a * b;
`endif
      default: begin e.r = '0; e.il = 1'b1; end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
    q.push_back(model(op, a, b));
  endtask

  task automatic test_reset();
    rst_i = 1'b0; step(); step();
    total++;
    if ({ready_o, valid_o, result_o, zero_o, illegal_o} !== {2'b10, {W{1'b0}}, 2'b10}) begin
      bad++; $display("FAIL reset_outs got rdy=%b v=%b r=%h z=%b il=%b want 1/0/0/1/0", ready_o, valid_o, result_o, zero_o, illegal_o);
    end
    rst_i = 1'b1; step();
  endtask

  task automatic test_add_sub();
    exp_t e;
    drive(4'b0010, 7, 5); step();
    drive(4'b0110, 5, 7);
    e = q.pop_front(); total++;
    if ({valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
      bad++; $display("FAIL add got v=%b r=%h z=%b il=%b want 1/%h/%b/%b", valid_o, result_o, zero_o, illegal_o, e.r, e.z, e.il);
    end
    step(); valid_i = 1'b0;
    e = q.pop_front(); total++;
    if ({valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
      bad++; $display("FAIL sub got v=%b r=%h z=%b il=%b want 1/%h/%b/%b", valid_o, result_o, zero_o, illegal_o, e.r, e.z, e.il);
    end
    step(); total++;
    if (valid_o !== 1'b0 || result_o !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL sub_hold got v=%b r=%h want 0/fffffffe", valid_o, result_o);
    end
  endtask

  task automatic test_logic();
    exp_t e;
    drive(4'b0000, 32'hF0F0_0000, 32'h0FF0_0000); step();
    drive(4'b0001, 32'h0000_000F, 32'h0000_00F0);
    e = q.pop_front(); total++;
    if ({valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
      bad++; $display("FAIL and got v=%b r=%h z=%b want 1/%h/%b", valid_o, result_o, zero_o, e.r, e.z);
    end
    step(); valid_i = 1'b0;
    e = q.pop_front(); total++;
    if ({valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
      bad++; $display("FAIL or got v=%b r=%h z=%b want 1/%h/%b", valid_o, result_o, zero_o, e.r, e.z);
    end
    step();
  endtask

  task automatic test_illegal(input logic [3:0] op);
    exp_t e;
    drive(op, 32'h1234, 32'h5678); step(); valid_i = 1'b0;
    e = q.pop_front(); total++;
    if ({valid_o, ready_o, result_o, zero_o, illegal_o} !== {2'b11, e}) begin
      bad++; $display("FAIL illegal_%h got v=%b rdy=%b r=%h z=%b il=%b want 1/1/%h/%b/%b", op, valid_o, ready_o, result_o, zero_o, illegal_o, e.r, e.z, e.il);
    end
    step(); total++;
    if ({valid_o, illegal_o} !== 2'b00) begin
      bad++; $display("FAIL illegal_pulse got v=%b il=%b want 0/0", valid_o, illegal_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0101, 4'b1111};
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      drive(codes[$urandom_range(0, 5)], $urandom, (i % 4 == 0) ? '0 : W'($urandom));
      step();
      e = q.pop_front(); total++;
      if ({valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
        bad++; $display("FAIL b2b_%0d got v=%b r=%h z=%b il=%b want 1/%h/%b/%b", i, valid_o, result_o, zero_o, illegal_o, e.r, e.z, e.il);
      end
    end
    valid_i = 1'b0; step();
  endtask

  task automatic test_flush_accept();
    logic [W-1:0] r0;
    r0 = result_o;
    valid_i = 1'b1; ALUCtrl_i = 4'b0010; data1_i = r0; data2_i = 1; flush_i = 1'b1;
    step(); valid_i = 1'b0; flush_i = 1'b0;
    total++;
    if ({valid_o, result_o} !== {1'b0, r0}) begin
      bad++; $display("FAIL flush_accept got v=%b r=%h want 0/%h", valid_o, result_o, r0);
    end
  endtask

`ifdef MC_ALU_MUL_EN
  task automatic test_mul();
    exp_t e;
    int n, low;
    drive(4'b0111, 123, 456); step();
    drive(4'b0010, 100, 23);
    n = 0; low = 0;
    while (!valid_o && n < 40) begin low += !ready_o; step(); n++; end
    total++;
    if (n != W || low != W) begin
      bad++; $display("FAIL mul_latency got cycles=%0d ready_low=%0d want %0d/%0d", n, low, W, W);
    end
    e = q.pop_front(); total++;
    if ({valid_o, ready_o, result_o, zero_o, illegal_o} !== {2'b11, e}) begin
      bad++; $display("FAIL mul_123x456 got v=%b rdy=%b r=%h z=%b want 1/1/%h/%b", valid_o, ready_o, result_o, zero_o, e.r, e.z);
    end
    step(); valid_i = 1'b0;
    e = q.pop_front(); total++;
    if ({valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
      bad++; $display("FAIL add_after_mul got v=%b r=%h want 1/%h", valid_o, result_o, e.r);
    end
  endtask

  task automatic test_mul_edge();
    exp_t e;
    int n;
    drive(4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step(); valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 40) begin step(); n++; end
    e = q.pop_front(); total++;
    if ({valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
      bad++; $display("FAIL mul_ones got v=%b r=%h z=%b want 1/%h/%b", valid_o, result_o, zero_o, e.r, e.z);
    end
    drive(4'b0111, 0, 9); step(); valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 40) begin step(); n++; end
    e = q.pop_front(); total++;
    if ({valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
      bad++; $display("FAIL mul_zero got v=%b r=%h z=%b want 1/%h/%b", valid_o, result_o, zero_o, e.r, e.z);
    end
  endtask

  task automatic test_mul_flush();
    exp_t e;
    logic [W-1:0] r0;
    int n, seen;
    r0 = result_o;
    valid_i = 1'b1; ALUCtrl_i = 4'b0111; data1_i = 3; data2_i = 3;
    step(); valid_i = 1'b0;
    repeat (9) step();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    total++;
    if ({valid_o, ready_o, result_o} !== {2'b01, r0}) begin
      bad++; $display("FAIL mul_flush got v=%b rdy=%b r=%h want 0/1/%h", valid_o, ready_o, result_o, r0);
    end
    seen = 0;
    repeat (40) begin seen += valid_o; step(); end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL mul_flush_quiet got pulses=%0d want 0", seen);
    end
    drive(4'b0111, 3, 3); step(); valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 40) begin step(); n++; end
    e = q.pop_front(); total++;
    if (n != W || {valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
      bad++; $display("FAIL mul_after_flush got cycles=%0d v=%b r=%h want %0d/1/%h", n, valid_o, result_o, W, e.r);
    end
  endtask

  task automatic test_mul_reset();
    int seen;
    valid_i = 1'b1; ALUCtrl_i = 4'b0111; data1_i = 3; data2_i = 3;
    step(); valid_i = 1'b0;
    repeat (9) step();
    rst_i = 1'b0; step(); rst_i = 1'b1;
    total++;
    if ({ready_o, valid_o, result_o, zero_o, illegal_o} !== {2'b10, {W{1'b0}}, 2'b10}) begin
      bad++; $display("FAIL mul_reset got rdy=%b v=%b r=%h z=%b il=%b want 1/0/0/1/0", ready_o, valid_o, result_o, zero_o, illegal_o);
    end
    seen = 0;
    repeat (40) begin seen += valid_o; step(); end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL mul_reset_quiet got pulses=%0d want 0", seen);
    end
  endtask
`endif

  task automatic test_reset_after();
    exp_t e;
    drive(4'b0010, 40, 2); step(); valid_i = 1'b0;
    e = q.pop_front(); total++;
    if ({valid_o, result_o, zero_o, illegal_o} !== {1'b1, e}) begin
      bad++; $display("FAIL pre_reset_add got v=%b r=%h want 1/%h", valid_o, result_o, e.r);
    end
    rst_i = 1'b0; step(); rst_i = 1'b1;
    total++;
    if ({ready_o, valid_o, result_o, zero_o, illegal_o} !== {2'b10, {W{1'b0}}, 2'b10}) begin
      bad++; $display("FAIL late_reset got rdy=%b v=%b r=%h z=%b il=%b want 1/0/0/1/0", ready_o, valid_o, result_o, zero_o, illegal_o);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_illegal(4'b0101);
    test_back_to_back();
    test_flush_accept();
`ifdef MC_ALU_MUL_EN
    test_mul();
    test_mul_edge();
    test_mul_flush();
    test_mul_reset();
`else
    test_illegal(4'b0111);
`endif
    test_reset_after();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_alu.md
# mc_alu

Multi-cycle execute-stage ALU that consumes the 4-bit ALU control code generated by the ALU control decoder and produces the EX-stage result. Logic ops and add/sub complete in one registered cycle. Multiply (code 4'b0111) runs as an iterative shift-add over WIDTH cycles, and the unit deasserts `ready_o` so the hazard unit can stall IF/ID/EX. It sits between the ID/EX pipeline register and the EX/MEM register.

## Interface
- `WIDTH`, 32, operand/result width in bits.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-low.
- `valid_i`  in  1  an operation is presented this cycle.
- `ALUCtrl_i`  in  4  operation code: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 mul.
- `data1_i`  in  WIDTH  operand A (rs1 / multiplicand).
- `data2_i`  in  WIDTH  operand B (rs2 or immediate / multiplier).
- `flush_i`  in  1  abort any in-flight operation.
- `ready_o`  out  1  unit can accept an operation at the next edge.
- `valid_o`  out  1  one-cycle pulse; `result_o` is new this cycle.
- `result_o`  out  WIDTH  last completed result, held between pulses.
- `zero_o`  out  1  `result_o == 0`, registered with `result_o`.
- `illegal_o`  out  1  pulses with `valid_o` when the code was unsupported.

## Operation
- States:
  - IDLE: `ready_o`=1.
  - MUL: `ready_o`=0.
- Accept: a rising edge with `valid_i && ready_o && !flush_i`.
- Single-cycle codes (and, or, add, sub):
  - `result_o` is updated at the accept edge and `valid_o`=1 for the following cycle.
  - The state stays IDLE.
- Add/sub are modulo 2^WIDTH. Carry and overflow are dropped.
- Mul, at the accept edge:
  - Latch A into the multiplicand register and B into the multiplier register.
  - Clear the WIDTH-bit accumulator and set counter=0.
  - Go to MUL.
- Each edge in MUL:
  - If multiplier[0]=1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
- The MUL edge on which counter==WIDTH-1 is the final one:
  - Write the accumulator to `result_o` and set `valid_o`=1.
  - Return to IDLE.
- The result is the low WIDTH bits of the unsigned product. The low half is identical for signed operands.
- Unsupported codes:
  - `result_o`=0, `zero_o`=1 and `illegal_o`=1, with single-cycle timing.
  - The code 0111 counts as unsupported when multiply is compiled out.
- `valid_i` while `ready_o`=0 is ignored. Upstream must hold the instruction until `ready_o` is high.
- `flush_i`:
  - Forces IDLE and clears the counter.
  - Suppresses `valid_o` at that edge.
  - Leaves `result_o` unchanged.
  - Wins over a simultaneous accept.
- Reset (`rst_i`=0 at an edge):
  - State IDLE, counter 0, internal registers 0.
  - `ready_o`=1, `valid_o`=0, `result_o`=0, `zero_o`=1, `illegal_o`=0.
  - Reset mid-multiply discards the operation, with no `valid_o`.

## Timing
- Single-cycle ops: `valid_o` is high in the cycle right after the accept edge. Back-to-back accepts give `valid_o` on every cycle.
- Mul:
  - `ready_o` is low for exactly WIDTH cycles after the accept edge.
  - `valid_o` and `ready_o` go high together in the cycle after the WIDTH-th MUL edge.
  - A new operation may be accepted on that same edge.
- There is no early termination when the multiplier becomes 0. The latency is fixed at WIDTH.
- `valid_o` and `illegal_o` are single-cycle pulses. `result_o` and `zero_o` change only on a `valid_o` edge or on reset.

## Configuration
- `MC_ALU_MUL_EN` defined:
  - The MUL state, counter, multiplicand/multiplier/accumulator registers and the 0111 decode are present.
- `MC_ALU_MUL_EN` undefined:
  - None of that logic is built, and `ready_o` is tied to 1.
  - Code 0111 is handled as unsupported: 1-cycle latency, `result_o`=0, `illegal_o`=1.

## Test plan
- Add, then sub: accept add 7+5, then sub 5-7 on the next edge.
  - Expect `valid_o` on two consecutive cycles.
  - `result_o`=12, then 0xFFFFFFFE. `zero_o`=0 both times.
- And/or: and 0xF0F0_0000 & 0x0FF0_0000 gives `result_o`=0x00F0_0000; or 0x0000_000F | 0x0000_00F0 gives 0x0000_00FF.
- Mul 123×456 (macro defined):
  - `ready_o`=0 for 32 cycles, then `valid_o`=1 with `result_o`=56088.
  - A second add presented during the mul is accepted only when `ready_o` returns to 1.
- Mul 0xFFFFFFFF×0xFFFFFFFF: `result_o`=0x00000001. A following mul 0×9 gives `result_o`=0 and `zero_o`=1.
- Flush and reset: start mul 3×3, then assert `flush_i` in MUL cycle 10.
  - Expect no `valid_o`, `ready_o`=1 the next cycle, and `result_o` unchanged.
  - Repeat with `rst_i`=0 instead: all outputs at their reset values.
- Illegal code: code 0101 gives `valid_o`=1, `illegal_o`=1 and `result_o`=0 one cycle later. With the macro undefined, code 0111 gives the same response.
